mdio_master: RTL and testbench

- Clause-22 MDIO management master. Sits directly downstream of the PHY configuration sequencer.
- Takes single-cycle write/read requests (PHY address, register address, write data) and serialises them onto MDC/MDIO.
- Returns read data and reports busy back to the sequencer.
- Tri-state MDIO pad is split into mdio_o, mdio_oe and mdio_i; the top level instantiates the pad.

---
 rtl/mdio_pkg.sv | 33 +++
 rtl/mdio_master_if.sv | 19 +
 rtl/mdio_master_mdc_gen.sv | 50 +++++
 rtl/mdio_master.sv | 222 ++++++++++++++++++++++
 tb/tb_mdio_master.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_pkg.sv
// Shared constants, FSM encoding and frame-assembly helper for the Clause-22 MDIO master.
package mdio_pkg;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] ST       = 2'b01;
  localparam logic [1:0] TA_WRITE = 2'b10;

  localparam int PHYAD_W   = 5;
  localparam int REGAD_W   = 5;
  localparam int DATA_W    = 16;
  localparam int HDR_SLOTS = 14;
  localparam int TA_SLOTS  = 2;

  localparam logic [4:0] S_IDLE     = 5'b00001;
  localparam logic [4:0] S_PREAMBLE = 5'b00010;
  localparam logic [4:0] S_HEADER   = 5'b00100;
  localparam logic [4:0] S_TA       = 5'b01000;
  localparam logic [4:0] S_DATA     = 5'b10000;

  typedef struct packed {
    logic [1:0]         op;
    logic [PHYAD_W-1:0] phy;
    logic [REGAD_W-1:0] regad;
    logic [DATA_W-1:0]  data;
  } mdio_req_t;

  // Post-preamble 32 bits, MSB first; TA/DATA bits are ignored on reads.
  function automatic logic [31:0] build_frame(input mdio_req_t r);
    return {ST, r.op, r.phy, r.regad, TA_WRITE, r.data};
  endfunction

endpackage

// File: rtl/mdio_master_if.sv
// Request/response bus between the PHY configuration sequencer and the MDIO master.
interface mdio_master_if;
  import mdio_pkg::*;

  logic [PHYAD_W-1:0] phy_add;
  logic [REGAD_W-1:0] reg_add;
  logic [DATA_W-1:0]  wr_data;
  logic               wren;
  logic               rden;
  logic               busy;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_valid;
  logic               rd_err;

  modport master (output phy_add, reg_add, wr_data, wren, rden,
                  input  busy, rd_data, rd_valid, rd_err);
  modport slave  (input  phy_add, reg_add, wr_data, wren, rden,
                  output busy, rd_data, rd_valid, rd_err);
endinterface

// File: rtl/mdio_master_mdc_gen.sv
// MDC divider: low then high for CLK_DIV cycles each, with strobes flagging the edge
// on which mdc will rise or fall. Held low with a cleared counter while disabled.
module mdc_gen #(
  parameter int CLK_DIV = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic mdc_o,
  output logic fall_tick_o,
  output logic rise_tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mdc_q, mdc_d;
  logic          wrap_s;

  assign wrap_s      = (cnt_q == CW'(CLK_DIV - 1));
  assign rise_tick_o = en_i & wrap_s & ~mdc_q;
  assign fall_tick_o = en_i & wrap_s & mdc_q;
  assign mdc_o       = mdc_q;

  always_comb begin
    cnt_d = cnt_q;
    mdc_d = mdc_q;
    if (!en_i) begin
      cnt_d = '0;
      mdc_d = 1'b0;
    end else if (wrap_s) begin
      cnt_d = '0;
      mdc_d = ~mdc_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
      mdc_d = mdc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: serialises single-cycle write/read requests onto MDC/MDIO
// and returns read data with a turnaround error flag.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV      = 20,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  mdio_master_if.slave        bus,
  output logic                mdc,
  output logic                mdio_o,
  output logic                mdio_oe,
  input  logic                mdio_i
);

  logic [4:0]        state_q, state_d;
  logic [5:0]        bit_q, bit_d;
  logic              busy_q, busy_d;
  logic [31:0]       tx_q, tx_d;
  logic              op_wr_q, op_wr_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              ta_err_q, ta_err_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;
  logic              mdio_o_q, mdio_o_d;
  logic              mdio_oe_q, mdio_oe_d;

  logic              fall_tick_s, rise_tick_s, req_s;
  mdio_req_t         req_fields_s;
  logic [31:0]       frame_s, tx_shift_s;
  logic              rel_bit_s;

  mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc_gen (
    .clk         (clk),
    .rst         (rst),
    .en_i        (busy_q),
    .mdc_o       (mdc),
    .fall_tick_o (fall_tick_s),
    .rise_tick_o (rise_tick_s)
  );

  // A simultaneous wren/rden resolves to a write.
  assign req_s              = bus.wren | bus.rden;
  assign req_fields_s.op    = bus.wren ? OP_WRITE : OP_READ;
  assign req_fields_s.phy   = bus.phy_add;
  assign req_fields_s.regad = bus.reg_add;
  assign req_fields_s.data  = bus.wr_data;
  assign frame_s            = build_frame(req_fields_s);
  assign tx_shift_s         = {tx_q[30:0], 1'b0};
  // Reads keep mdio_o idle-high once the bus is released.
  assign rel_bit_s          = op_wr_q ? tx_q[31] : 1'b1;

  assign bus.busy     = busy_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign mdio_o       = mdio_o_q;
  assign mdio_oe      = mdio_oe_q;

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    busy_d     = busy_q;
    tx_d       = tx_q;
    op_wr_d    = op_wr_q;
    rx_d       = rx_q;
    ta_err_d   = ta_err_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_err_d   = rd_err_q;
    mdio_o_d   = mdio_o_q;
    mdio_oe_d  = mdio_oe_q;

    // PHY-driven bits are sampled on the rising MDC edge.
    if (rise_tick_s) begin
      if (state_q == S_DATA) begin
        rx_d = {rx_q[DATA_W-2:0], mdio_i};
      end else if ((state_q == S_TA) && (bit_q == 6'd1)) begin
        ta_err_d = mdio_i;
      end else begin
        rx_d = rx_q;
      end
    end else begin
      rx_d = rx_q;
    end

    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          busy_d    = 1'b1;
          bit_d     = 6'd0;
          op_wr_d   = bus.wren;
          ta_err_d  = 1'b0;
          mdio_oe_d = 1'b1;
          if (PREAMBLE_LEN == 0) begin
            state_d  = S_HEADER;
            mdio_o_d = frame_s[31];
            tx_d     = {frame_s[30:0], 1'b0};
          end else begin
            state_d  = S_PREAMBLE;
            mdio_o_d = 1'b1;
            tx_d     = frame_s;
          end
        end else begin
          mdio_o_d  = 1'b1;
          mdio_oe_d = 1'b0;
        end
      end
      S_PREAMBLE: begin
        if (fall_tick_s) begin
          if (bit_q == 6'(PREAMBLE_LEN - 1)) begin
            state_d  = S_HEADER;
            bit_d    = 6'd0;
            mdio_o_d = tx_q[31];
            tx_d     = tx_shift_s;
          end else begin
            bit_d    = bit_q + 6'd1;
            mdio_o_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_HEADER: begin
        if (fall_tick_s) begin
          tx_d = tx_shift_s;
          if (bit_q == 6'(HDR_SLOTS - 1)) begin
            state_d   = S_TA;
            bit_d     = 6'd0;
            mdio_oe_d = op_wr_q;
            mdio_o_d  = rel_bit_s;
          end else begin
            bit_d    = bit_q + 6'd1;
            mdio_o_d = tx_q[31];
          end
        end else begin
          state_d = state_q;
        end
      end
      S_TA: begin
        if (fall_tick_s) begin
          tx_d     = tx_shift_s;
          mdio_o_d = rel_bit_s;
          if (bit_q == 6'(TA_SLOTS - 1)) begin
            state_d = S_DATA;
            bit_d   = 6'd0;
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_DATA: begin
        if (fall_tick_s) begin
          if (bit_q == 6'(DATA_W - 1)) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            bit_d     = 6'd0;
            mdio_o_d  = 1'b1;
            mdio_oe_d = 1'b0;
            if (!op_wr_q) begin
              rd_data_d  = rx_q;
              rd_valid_d = 1'b1;
              rd_err_d   = ta_err_q;
            end else begin
              rd_data_d = rd_data_q;
            end
          end else begin
            tx_d     = tx_shift_s;
            mdio_o_d = rel_bit_s;
            bit_d    = bit_q + 6'd1;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        bit_d     = 6'd0;
        mdio_o_d  = 1'b1;
        mdio_oe_d = 1'b0;
      end
    endcase
  end

  // Synchronous reset aborts any frame on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_q      <= 6'd0;
      busy_q     <= 1'b0;
      tx_q       <= 32'd0;
      op_wr_q    <= 1'b0;
      rx_q       <= 16'd0;
      ta_err_q   <= 1'b0;
      rd_data_q  <= 16'd0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      mdio_o_q   <= 1'b1;
      mdio_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      busy_q     <= busy_d;
      tx_q       <= tx_d;
      op_wr_q    <= op_wr_d;
      rx_q       <= rx_d;
      ta_err_q   <= ta_err_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      mdio_o_q   <= mdio_o_d;
      mdio_oe_q  <= mdio_oe_d;
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master: a cycle-indexed frame model plus a PHY responder.
module tb_mdio_master;

  localparam int D     = 2;
  localparam int P     = 32;
  localparam int NSLOT = P + 32;
  localparam int T     = NSLOT * 2 * D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mdc, mdio_o, mdio_oe;
  logic mdio_i = 1'b1;

  mdio_master_if bus();

  mdio_master #(.CLK_DIV(D), .PREAMBLE_LEN(P)) dut (
    .clk(clk), .rst(rst), .bus(bus), .mdc(mdc),
    .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: m_k is the cycle index within the active frame.
  bit          m_active = 1'b0;
  int          m_k = 0;
  bit          m_wr = 1'b0;
  logic [4:0]  m_phy = 5'd0, m_reg = 5'd0;
  logic [15:0] m_wdata = 16'd0, m_resp = 16'd0, m_rd_data = 16'd0;
  bit          m_ta2 = 1'b0, m_rd_err = 1'b0, m_valid = 1'b0;

  // PHY behaviour chosen by stimulus before each request.
  bit          phy_present = 1'b1;
  logic [15:0] phy_data = 16'd0;
  bit          phy_ta2 = 1'b0;

  int          cap_busy, cap_bits, cap_first_low, cap_valid;
  logic [63:0] cap_stream;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_bit(input int s);
    logic [31:0] f;
    f = {2'b01, (m_wr ? 2'b01 : 2'b10), m_phy, m_reg, 2'b10, m_wdata};
    if (s < P) return 1'b1;
    return f[31 - (s - P)];
  endfunction

  function automatic bit exp_oe(input int s);
    return m_wr || (s < P + 14);
  endfunction

  // Reference model advances on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_active  <= 1'b0;
      m_k       <= 0;
      m_rd_data <= 16'd0;
      m_rd_err  <= 1'b0;
      m_valid   <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (m_active) begin
        if (m_k == T - 1) begin
          m_active <= 1'b0;
          if (!m_wr) begin
            m_rd_data <= m_resp;
            m_rd_err  <= m_ta2;
            m_valid   <= 1'b1;
          end
        end else begin
          m_k <= m_k + 1;
        end
      end else if (bus.wren || bus.rden) begin
        m_active <= 1'b1;
        m_k      <= 0;
        m_wr     <= bus.wren;
        m_phy    <= bus.phy_add;
        m_reg    <= bus.reg_add;
        m_wdata  <= bus.wr_data;
        m_resp   <= phy_present ? phy_data : 16'hFFFF;
        m_ta2    <= phy_present ? phy_ta2 : 1'b1;
      end
    end
  end

  // Compare every cycle on the falling edge, then drive the PHY response bit.
  always @(negedge clk) begin
    int slot, ph, s;
    slot = m_k / (2 * D);
    ph   = m_k % (2 * D);
    if (chk_en) begin
      if (m_active) begin
        chk("busy", {31'd0, bus.busy}, 32'd1);
        chk("mdc", {31'd0, mdc}, {31'd0, (ph >= D)});
        chk("mdio_oe", {31'd0, mdio_oe}, {31'd0, exp_oe(slot)});
        if (exp_oe(slot)) chk("mdio_o", {31'd0, mdio_o}, {31'd0, exp_bit(slot)});
        chk("rd_valid", {31'd0, bus.rd_valid}, 32'd0);
      end else begin
        chk("busy_idle", {31'd0, bus.busy}, 32'd0);
        chk("mdc_idle", {31'd0, mdc}, 32'd0);
        chk("mdio_oe_idle", {31'd0, mdio_oe}, 32'd0);
        chk("mdio_o_idle", {31'd0, mdio_o}, 32'd1);
        chk("rd_valid_idle", {31'd0, bus.rd_valid}, {31'd0, m_valid});
      end
      chk("rd_data", {16'd0, bus.rd_data}, {16'd0, m_rd_data});
      chk("rd_err", {31'd0, bus.rd_err}, {31'd0, m_rd_err});
    end
    if (m_active && !m_wr && slot >= P + 14) begin
      s = slot - (P + 14);
      if (s == 0)      mdio_i = 1'b1;
      else if (s == 1) mdio_i = m_ta2;
      else             mdio_i = m_resp[15 - (s - 2)];
    end else begin
      mdio_i = 1'b1;
    end
  end

  // Called just after a falling edge; the request is seen on the next rising edge.
  task automatic do_req(input bit wr, input bit rd, input logic [4:0] pa,
                        input logic [4:0] ra, input logic [15:0] wd);
    bus.wren = wr; bus.rden = rd;
    bus.phy_add = pa; bus.reg_add = ra; bus.wr_data = wd;
    @(posedge clk); #1;
    bus.wren = 1'b0; bus.rden = 1'b0;
  endtask

  // Follow one frame: count busy cycles, record mdio_o/oe at each MDC rise.
  task automatic capture();
    bit seen;
    logic prev;
    cap_busy = 0; cap_bits = 0; cap_first_low = 99; cap_valid = 0;
    cap_stream = 64'd0; seen = 1'b0; prev = mdc;
    for (int i = 0; i < 4 * T; i++) begin
      @(negedge clk);
      if (bus.busy) begin seen = 1'b1; cap_busy++; end
      if (bus.rd_valid) cap_valid++;
      if (mdc && !prev) begin
        cap_stream = {cap_stream[62:0], mdio_o};
        if (!mdio_oe && cap_first_low == 99) cap_first_low = cap_bits;
        cap_bits++;
      end
      prev = mdc;
      if (seen && !bus.busy) return;
    end
    checks++; errors++;
    $display("FAIL capture_timeout frame did not complete within %0d cycles", 4 * T);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] mf;
    int vcnt;
    bus.wren = 1'b0; bus.rden = 1'b0;
    bus.phy_add = 5'd0; bus.reg_add = 5'd0; bus.wr_data = 16'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_mdio_o", {31'd0, mdio_o}, 32'd1);
    chk("reset_rd_data", {16'd0, bus.rd_data}, 32'd0);

    // Plain write, pinned to hand-computed literals.
    do_req(1'b1, 1'b0, 5'h0F, 5'h00, 16'h1100);
    capture();
    chk("wr_busy_cycles", cap_busy, 32'd256);
    chk("wr_bits", cap_bits, 32'd64);
    chk("wr_stream_hi", cap_stream[63:32], 32'hFFFFFFFF);
    chk("wr_stream_lo", cap_stream[31:0], 32'h57821100);
    chk("wr_oe_never_low", cap_first_low, 32'd99);
    chk("wr_no_rd_valid", cap_valid, 32'd0);
    for (int s = 0; s < 32; s++) mf[31 - s] = exp_bit(P + s);
    chk("model_frame", mf, 32'h57821100);

    // Read with a responding PHY.
    @(negedge clk);
    phy_present = 1'b1; phy_data = 16'h0283; phy_ta2 = 1'b0;
    do_req(1'b0, 1'b1, 5'h0F, 5'h02, 16'h0000);
    capture();
    chk("rd_header", {18'd0, cap_stream[31:18]}, {18'd0, 14'b01_10_01111_00010});
    chk("rd_oe_fall_slot", cap_first_low, 32'd46);
    chk("rd_busy_cycles", cap_busy, 32'd256);
    chk("rd_valid_once", cap_valid, 32'd1);
    chk("rd_data_lit", {16'd0, bus.rd_data}, 32'h0283);
    chk("rd_err_lit", {31'd0, bus.rd_err}, 32'd0);

    // Read with no PHY: bus floats high.
    phy_present = 1'b0;
    do_req(1'b0, 1'b1, 5'h03, 5'h01, 16'h0000);
    capture();
    chk("nophy_rd_err", {31'd0, bus.rd_err}, 32'd1);
    chk("nophy_rd_data", {16'd0, bus.rd_data}, 32'hFFFF);
    chk("nophy_valid_once", cap_valid, 32'd1);

    // wren and rden together: write wins.
    phy_present = 1'b1;
    do_req(1'b1, 1'b1, 5'h11, 5'h05, 16'hA5C3);
    capture();
    chk("both_st_op", {28'd0, cap_stream[31:28]}, 32'h5);
    chk("both_oe_never_low", cap_first_low, 32'd99);
    chk("both_no_valid", cap_valid, 32'd0);

    // Second wren 10 cycles into a frame is dropped.
    do_req(1'b1, 1'b0, 5'h01, 5'h02, 16'h1234);
    fork
      capture();
      begin
        repeat (9) @(negedge clk);
        do_req(1'b1, 1'b0, 5'h1F, 5'h1F, 16'hFFFF);
      end
    join
    chk("drop_busy_cycles", cap_busy, 32'd256);
    chk("drop_frame_data", {16'd0, cap_stream[15:0]}, 32'h1234);
    repeat (5) @(negedge clk);
    chk("drop_no_second", {31'd0, bus.busy}, 32'd0);

    // Reset in the middle of a read's DATA phase.
    phy_data = 16'hBEEF; phy_ta2 = 1'b0;
    do_req(1'b0, 1'b1, 5'h07, 5'h09, 16'h0000);
    repeat ((P + 20) * 2 * D) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mdc", {31'd0, mdc}, 32'd0);
    chk("rst_mdio_o", {31'd0, mdio_o}, 32'd1);
    chk("rst_mdio_oe", {31'd0, mdio_oe}, 32'd0);
    chk("rst_rd_data", {16'd0, bus.rd_data}, 32'd0);
    vcnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.rd_valid) vcnt++;
    end
    chk("rst_no_rd_valid", vcnt, 32'd0);
    do_req(1'b1, 1'b0, 5'h0F, 5'h00, 16'h1100);
    capture();
    chk("post_rst_busy", cap_busy, 32'd256);
    chk("post_rst_frame", cap_stream[31:0], 32'h57821100);

    // Randomised back-to-back traffic checked by the model.
    for (int it = 0; it < 24; it++) begin
      int kind, gap;
      kind = $urandom_range(0, 2);
      gap  = $urandom_range(0, 3);
      phy_present = ($urandom_range(0, 3) != 0);
      phy_data    = 16'($urandom);
      phy_ta2     = ($urandom_range(0, 3) == 0);
      repeat (gap) @(negedge clk);
      do_req(kind != 1, kind != 0, 5'($urandom), 5'($urandom), 16'($urandom));
      capture();
      chk("rand_busy_cycles", cap_busy, T);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
